// File: rtl/osc_tick_gen_pkg.sv
// osc_tick_pkg: shared definitions for the oscillator tick generator.
//   DIV_W_DEF       default divisor width
//   DEFAULT_DIV_DEF default divisor loaded at reset
//   div_eff()       maps a divisor of 0 onto 1 (0 and 1 behave identically)
//   ch_w()          width of a channel index, never less than 1 bit
// Divisor widths up to 32 bits are supported by div_eff().
package osc_tick_pkg;

  localparam int DIV_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 128;

  // A zero divisor would otherwise never reach a boundary, so it is
  // treated as a divide-by-one.
  function automatic logic [31:0] div_eff(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // A single-channel build still needs a one-bit channel select.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/osc_tick_gen_if.sv
// osc_tick_if: configuration and output bundle of osc_tick_gen.
//   ch_en   [NCH]   per-channel run enable
//   cfg_wr          one-cycle divisor write strobe
//   cfg_ch  [CH_W]  target channel of the write
//   cfg_div [DIV_W] new divisor
//   pend    [NCH]   divisor written but not yet applied
//   tick    [NCH]   one-cycle pulse per period
//   sq      [NCH]   divided square wave aligned to tick
// Modports: master drives configuration, slave is the generator.
interface osc_tick_if
  import osc_tick_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DIV_W = DIV_W_DEF
);

  localparam int CH_W = ch_w(NCH);

  logic [NCH-1:0]   ch_en;
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   sq;

  modport master (
    output ch_en, cfg_wr, cfg_ch, cfg_div,
    input  pend, tick, sq
  );

  modport slave (
    input  ch_en, cfg_wr, cfg_ch, cfg_div,
    output pend, tick, sq
  );

endinterface

// File: rtl/osc_tick_gen_chan.sv
// osc_tick_chan: one divided clock-enable channel.
//   clk, rst_n  oscillator clock, synchronous active-low reset
//   en          run enable
//   wr, wr_div  divisor write into the shadow register
//   force_bnd   treat this edge as a period boundary (phase sync)
//   pend        shadow written but not yet applied
//   tick        one-cycle pulse at the start of each period
//   sq          high for the first floor(div/2) cycles of each period
module osc_tick_chan
  import osc_tick_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             force_bnd,
  output logic             pend,
  output logic             tick,
  output logic             sq
);

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t RST_DIV = div_t'(DEFAULT_DIV);
  localparam div_t RST_CNT = div_t'(DEFAULT_DIV - 1);
  localparam div_t ONE     = div_t'(1);

  div_t div_reg;
  div_t shadow;
  div_t cnt;
  logic en_d;

  div_t next_div;
  div_t next_eff;
  div_t cur_eff;
  div_t shadow_eff;
  div_t cnt_dec;
  div_t sq_thr;
  logic bnd;

  // Next-period divisor selection and boundary detection. The edge on
  // which the enable is first seen only arms the counter (en_d low), so
  // the first tick lands a full period after enable; this also keeps a
  // divide-by-one channel from ticking on its very first enabled edge.
  // sq stays high while the count is at or above div - floor(div/2).
  always_comb begin
    next_div   = pend ? shadow : div_reg;
    next_eff   = div_t'(div_eff(32'(next_div)));
    cur_eff    = div_t'(div_eff(32'(div_reg)));
    shadow_eff = div_t'(div_eff(32'(shadow)));
    cnt_dec    = cnt - ONE;
    sq_thr     = cur_eff - (cur_eff >> 1);
    bnd        = en && (force_bnd || (en_d && (cnt == '0)));
  end

  // Channel state. A disabled channel continuously preloads a full period
  // from the shadow so re-enable never produces a partial period. A write
  // is placed last so it always wins over the pend clear of a boundary or
  // of the disabled state; a boundary on the write edge therefore still
  // uses the value it read before the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_reg <= RST_DIV;
      shadow  <= RST_DIV;
      cnt     <= RST_CNT;
      en_d    <= 1'b0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        div_reg <= shadow;
        cnt     <= shadow_eff - ONE;
        pend    <= 1'b0;
        tick    <= 1'b0;
        sq      <= 1'b0;
      end else if (bnd) begin
        div_reg <= next_div;
        cnt     <= next_eff - ONE;
        pend    <= 1'b0;
        tick    <= 1'b1;
        sq      <= (next_eff > ONE);
      end else begin
        tick <= 1'b0;
        if (en_d) begin
          cnt <= cnt_dec;
          sq  <= sq && (cnt_dec >= sq_thr);
        end
      end
      if (wr) begin
        shadow <= wr_div;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/osc_tick_gen.sv
// osc_tick_gen: NCH-channel programmable clock-enable generator on the
// oscillator clock. Each channel produces a tick pulse and square wave at
// clk / divisor; divisor changes apply only at period boundaries.
//   clk    oscillator clock
//   rst_n  synchronous active-low reset
//   sync   (OSC_TICK_SYNC_EN only) force a boundary on all enabled channels
//   bus    osc_tick_if.slave: ch_en, cfg_wr/cfg_ch/cfg_div, pend, tick, sq
// Build option: define OSC_TICK_SYNC_EN to add the sync input; without it
// every channel free-runs independently.
module osc_tick_gen
  import osc_tick_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef OSC_TICK_SYNC_EN
  input  logic       sync,
`endif
  osc_tick_if.slave  bus
);

  logic [NCH-1:0] wr_sel;
  logic [NCH-1:0] pend_v;
  logic [NCH-1:0] tick_v;
  logic [NCH-1:0] sq_v;
  logic           force_bnd;

  // Write decode: channel indices at or above NCH match nothing, so such
  // writes are silently dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i] = bus.cfg_wr && (int'(bus.cfg_ch) == i);
    end
  end

`ifdef OSC_TICK_SYNC_EN
  assign force_bnd = sync;
`else
  assign force_bnd = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    osc_tick_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bus.ch_en[g]),
      .wr        (wr_sel[g]),
      .wr_div    (bus.cfg_div),
      .force_bnd (force_bnd),
      .pend      (pend_v[g]),
      .tick      (tick_v[g]),
      .sq        (sq_v[g])
    );
  end

  assign bus.pend = pend_v;
  assign bus.tick = tick_v;
  assign bus.sq   = sq_v;

endmodule

// File: tb/tb_osc_tick_gen.sv
// tb_osc_tick_gen: self-checking bench for osc_tick_gen (NCH=5 so that
// out-of-range channel writes can be expressed). Expected tick edges are
// queued when stimulus is applied and popped as ticks appear. The sync
// scenario is built only when OSC_TICK_SYNC_EN is defined.
module tb_osc_tick_gen;
  import osc_tick_pkg::*;

  localparam int NCH         = 5;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 128;

  logic clk = 1'b0;
  logic rst_n;
`ifdef OSC_TICK_SYNC_EN
  logic sync;
`endif

  osc_tick_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

  osc_tick_gen #(
    .NCH         (NCH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef OSC_TICK_SYNC_EN
    .sync  (sync),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Label of the most recent rising edge, read on falling edges.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int passes = 0;
  int exp_q[$];
  int exp_q1[$];

  // Reset with a write in flight; all outputs must be cleared.
  task automatic test_reset();
    rst_n       = 1'b0;
    bus.ch_en   = '0;
    bus.cfg_wr  = 1'b1;
    bus.cfg_ch  = 3'd0;
    bus.cfg_div = 16'd3;
`ifdef OSC_TICK_SYNC_EN
    sync = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (bus.tick !== 5'b0) $display("[TB] FAIL reset_tick: got %b expected 00000", bus.tick); else passes++;
    checks++; if (bus.sq !== 5'b0) $display("[TB] FAIL reset_sq: got %b expected 00000", bus.sq); else passes++;
    checks++; if (bus.pend !== 5'b0) $display("[TB] FAIL reset_pend: got %b expected 00000", bus.pend); else passes++;
  endtask

  // Channel 0 at the reset divisor: first tick 128 edges after enable,
  // period 128, sq 64 high / 64 low, pend never set.
  task automatic test_default_div();
    int k, t, sq_bad, pend_bad;
    exp_q.delete();
    sq_bad = 0; pend_bad = 0;
    rst_n = 1'b1; bus.cfg_wr = 1'b0; bus.ch_en[0] = 1'b1;
    k = edge_n + 1;
    exp_q.push_back(k + 128); exp_q.push_back(k + 256);
    while (edge_n < k + 260) begin
      @(negedge clk);
      if (bus.tick[0]) begin
        checks++;
        if (exp_q.size() != 0) t = exp_q.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL default_tick: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
      if (bus.sq[0] !== ((edge_n >= k + 128) && (((edge_n - k - 128) % 128) < 64))) sq_bad++;
      if (bus.pend[0] !== 1'b0) pend_bad++;
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL default_missing: got %0d left expected 0", exp_q.size()); else passes++;
    checks++; if (sq_bad != 0) $display("[TB] FAIL default_sq: got %0d bad cycles expected 0", sq_bad); else passes++;
    checks++; if (pend_bad != 0) $display("[TB] FAIL default_pend: got %0d bad cycles expected 0", pend_bad); else passes++;
  endtask

  // Write 5 to running channel 1: pend until the next boundary, which
  // then starts period 5 with sq pattern 11000.
  task automatic test_shadow_apply();
    int k, t, sq_bad, pend_bad;
    exp_q.delete();
    sq_bad = 0; pend_bad = 0;
    bus.ch_en[1] = 1'b1;
    k = edge_n + 1;
    exp_q.push_back(k + 128); exp_q.push_back(k + 133);
    exp_q.push_back(k + 138); exp_q.push_back(k + 143);
    while (edge_n < k + 145) begin
      @(negedge clk);
      if (bus.tick[1]) begin
        checks++;
        if (exp_q.size() != 0) t = exp_q.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL shadow_tick: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
      if (bus.sq[1] !== ((edge_n >= k + 128) && (((edge_n - k - 128) % 5) < 2))) sq_bad++;
      if (bus.pend[1] !== ((edge_n >= k + 21) && (edge_n < k + 128))) pend_bad++;
      bus.cfg_wr  = (edge_n == k + 20);
      bus.cfg_ch  = 3'd1;
      bus.cfg_div = 16'd5;
    end
    bus.cfg_wr = 1'b0;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL shadow_missing: got %0d left expected 0", exp_q.size()); else passes++;
    checks++; if (sq_bad != 0) $display("[TB] FAIL shadow_sq: got %0d bad cycles expected 0", sq_bad); else passes++;
    checks++; if (pend_bad != 0) $display("[TB] FAIL shadow_pend: got %0d bad cycles expected 0", pend_bad); else passes++;
  endtask

  // Divisor 0 then 1 on channel 2: tick every cycle, sq constant 0.
  task automatic test_div_zero_one();
    int k, t, sq_bad;
    exp_q.delete();
    sq_bad = 0;
    bus.cfg_wr = 1'b1; bus.cfg_ch = 3'd2; bus.cfg_div = 16'd0;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    checks++; if (bus.pend[2] !== 1'b1) $display("[TB] FAIL zero_pend_set: got %b expected 1", bus.pend[2]); else passes++;
    @(negedge clk);
    checks++; if (bus.pend[2] !== 1'b0) $display("[TB] FAIL zero_pend_disabled: got %b expected 0", bus.pend[2]); else passes++;
    bus.ch_en[2] = 1'b1;
    k = edge_n + 1;
    for (int j = 1; j <= 14; j++) exp_q.push_back(k + j);
    while (edge_n < k + 14) begin
      @(negedge clk);
      if (bus.tick[2]) begin
        checks++;
        if (exp_q.size() != 0) t = exp_q.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL zero_tick: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
      if (bus.sq[2] !== 1'b0) sq_bad++;
      if (edge_n == k + 6) begin
        checks++; if (bus.pend[2] !== 1'b1) $display("[TB] FAIL one_pend_set: got %b expected 1", bus.pend[2]); else passes++;
      end
      if (edge_n == k + 7) begin
        checks++; if (bus.pend[2] !== 1'b0) $display("[TB] FAIL one_pend_clear: got %b expected 0", bus.pend[2]); else passes++;
      end
      bus.cfg_wr  = (edge_n == k + 5);
      bus.cfg_ch  = 3'd2;
      bus.cfg_div = 16'd1;
    end
    bus.cfg_wr = 1'b0;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL zero_missing: got %0d left expected 0", exp_q.size()); else passes++;
    checks++; if (sq_bad != 0) $display("[TB] FAIL zero_sq: got %0d bad cycles expected 0", sq_bad); else passes++;
  endtask

  // Channel 3: write 9 on a boundary edge, then 3 before the next one.
  // The coincident boundary keeps 128, then period 3; 9 never applies.
  task automatic test_back_to_back();
    int k, t, sq_bad;
    exp_q.delete();
    sq_bad = 0;
    bus.ch_en[3] = 1'b1;
    k = edge_n + 1;
    exp_q.push_back(k + 128); exp_q.push_back(k + 256);
    exp_q.push_back(k + 259); exp_q.push_back(k + 262);
    while (edge_n < k + 264) begin
      @(negedge clk);
      if (bus.tick[3]) begin
        checks++;
        if (exp_q.size() != 0) t = exp_q.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL b2b_tick: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
      if ((edge_n >= k + 256) && (bus.sq[3] !== (((edge_n - k - 256) % 3) < 1))) sq_bad++;
      if (edge_n == k + 128) begin
        checks++; if (bus.pend[3] !== 1'b1) $display("[TB] FAIL b2b_pend_set: got %b expected 1", bus.pend[3]); else passes++;
      end
      if (edge_n == k + 256) begin
        checks++; if (bus.pend[3] !== 1'b0) $display("[TB] FAIL b2b_pend_clear: got %b expected 0", bus.pend[3]); else passes++;
      end
      bus.cfg_ch  = 3'd3;
      bus.cfg_wr  = (edge_n == k + 127) || (edge_n == k + 139);
      bus.cfg_div = (edge_n == k + 127) ? 16'd9 : 16'd3;
    end
    bus.cfg_wr = 1'b0;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL b2b_missing: got %0d left expected 0", exp_q.size()); else passes++;
    checks++; if (sq_bad != 0) $display("[TB] FAIL b2b_sq: got %0d bad cycles expected 0", sq_bad); else passes++;
  endtask

  // Drop channel 0 at count 40, load divisor 8 while off, re-enable after
  // 10 disabled edges: silent while off, first tick 8 edges after enable.
  task automatic test_disable();
    int tk, k, t, sq_bad;
    exp_q.delete();
    sq_bad = 0;
    tk = -1;
    for (int i = 0; (i < 200) && (tk < 0); i++) begin
      @(negedge clk);
      if (bus.tick[0]) tk = edge_n;
    end
    checks++;
    if (tk < 0) begin
      $display("[TB] FAIL disable_find_tick: got %0d expected a tick within 200 edges", tk);
      tk = edge_n;
    end else passes++;
    while (edge_n < tk + 87) @(negedge clk);
    bus.ch_en[0] = 1'b0;
    k = tk + 98;
    exp_q.push_back(k + 8); exp_q.push_back(k + 16); exp_q.push_back(k + 24);
    while (edge_n < k + 26) begin
      @(negedge clk);
      if (bus.tick[0]) begin
        checks++;
        if (exp_q.size() != 0) t = exp_q.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL disable_tick: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
      if (bus.sq[0] !== ((edge_n >= k + 8) && (((edge_n - k - 8) % 8) < 4))) sq_bad++;
      if (edge_n == tk + 89) begin
        checks++; if (bus.pend[0] !== 1'b1) $display("[TB] FAIL disable_pend_set: got %b expected 1", bus.pend[0]); else passes++;
      end
      if (edge_n == tk + 90) begin
        checks++; if (bus.pend[0] !== 1'b0) $display("[TB] FAIL disable_pend_clear: got %b expected 0", bus.pend[0]); else passes++;
      end
      bus.cfg_wr  = (edge_n == tk + 88);
      bus.cfg_ch  = 3'd0;
      bus.cfg_div = 16'd8;
      if (edge_n == k - 1) bus.ch_en[0] = 1'b1;
    end
    bus.cfg_wr = 1'b0;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL disable_missing: got %0d left expected 0", exp_q.size()); else passes++;
    checks++; if (sq_bad != 0) $display("[TB] FAIL disable_sq: got %0d bad cycles expected 0", sq_bad); else passes++;
  endtask

  // Writes to channel indices 5..7 must not mark any channel pending.
  task automatic test_out_of_range();
    for (int c = 5; c < 8; c++) begin
      bus.cfg_wr  = 1'b1;
      bus.cfg_ch  = 3'(c);
      bus.cfg_div = 16'd2;
      @(negedge clk);
      checks++; if (bus.pend !== 5'b0) $display("[TB] FAIL oor_pend_ch%0d: got %b expected 00000", c, bus.pend); else passes++;
    end
    bus.cfg_wr = 1'b0;
  endtask

`ifdef OSC_TICK_SYNC_EN
  // Channel 0 -> 7, channel 1 -> 11, then sync: both tick right after the
  // sync edge and then run at 7 and 11 from that point.
  task automatic test_sync();
    int s, t;
    exp_q.delete(); exp_q1.delete();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 3'd0; bus.cfg_div = 16'd7;
    @(negedge clk);
    bus.cfg_ch = 3'd1; bus.cfg_div = 16'd11;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    sync = 1'b1;
    s = edge_n + 1;
    exp_q.push_back(s); exp_q.push_back(s + 7); exp_q.push_back(s + 14); exp_q.push_back(s + 21);
    exp_q1.push_back(s); exp_q1.push_back(s + 11); exp_q1.push_back(s + 22);
    while (edge_n < s + 23) begin
      @(negedge clk);
      sync = 1'b0;
      if (bus.tick[0]) begin
        checks++;
        if (exp_q.size() != 0) t = exp_q.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL sync_tick_ch0: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
      if (bus.tick[1]) begin
        checks++;
        if (exp_q1.size() != 0) t = exp_q1.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL sync_tick_ch1: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL sync_missing_ch0: got %0d left expected 0", exp_q.size()); else passes++;
    checks++; if (exp_q1.size() != 0) $display("[TB] FAIL sync_missing_ch1: got %0d left expected 0", exp_q1.size()); else passes++;
  endtask
`endif

  // Reset while running with a write in flight: outputs clear, the write
  // is lost and channel 1 restarts at the reset divisor.
  task automatic test_reset_midrun();
    int k, t;
    exp_q.delete();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 3'd1; bus.cfg_div = 16'd4;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.tick !== 5'b0) $display("[TB] FAIL midreset_tick: got %b expected 00000", bus.tick); else passes++;
    checks++; if (bus.sq !== 5'b0) $display("[TB] FAIL midreset_sq: got %b expected 00000", bus.sq); else passes++;
    checks++; if (bus.pend !== 5'b0) $display("[TB] FAIL midreset_pend: got %b expected 00000", bus.pend); else passes++;
    rst_n = 1'b1; bus.cfg_wr = 1'b0;
    k = edge_n + 1;
    exp_q.push_back(k + 128);
    while (edge_n < k + 130) begin
      @(negedge clk);
      if (bus.tick[1]) begin
        checks++;
        if (exp_q.size() != 0) t = exp_q.pop_front(); else t = -1;
        if (edge_n !== t) $display("[TB] FAIL midreset_ch1_tick: got edge %0d expected edge %0d", edge_n, t); else passes++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL midreset_missing: got %0d left expected 0", exp_q.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_shadow_apply();
    test_div_zero_one();
    test_back_to_back();
    test_disable();
    test_out_of_range();
`ifdef OSC_TICK_SYNC_EN
    test_sync();
`endif
    test_reset_midrun();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout at edge %0d expected completion", edge_n);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/osc_tick_gen.md
Name: osc_tick_gen

Overview:
- Parametrised multi-channel clock-enable generator running on the on-chip oscillator clock.
- Replaces fixed-divide oscillator outputs with NCH independent, runtime-programmable divided tick/square outputs.
- Consumers use `tick` as a clock enable, so all logic stays in one clock domain.
- Divisor changes are glitch-free: they take effect only at period boundaries.

Parameters:
- NCH, 4, number of output channels (1..16).
- DIV_W, 16, divisor width in bits.
- DEFAULT_DIV, 128, divisor loaded into every channel at reset (1..2^DIV_W-1).

Ports:
- clk  in  1  oscillator clock, single domain.
- rst_n  in  1  synchronous active-low reset.
- ch_en  in  NCH  per-channel run enable.
- cfg_wr  in  1  one-cycle divisor write strobe.
- cfg_ch  in  $clog2(NCH) (min 1)  target channel of write.
- cfg_div  in  DIV_W  new divisor.
- pend  out  NCH  shadow divisor written but not yet applied.
- tick  out  NCH  one-cycle pulse per period.
- sq  out  NCH  divided square wave, aligned to tick.

Behaviour:
- One clock, `clk`; reset is synchronous and active-low (`rst_n`), sampled on the rising edge of `clk`.
- Reset values per channel:
  - div_reg = shadow = DEFAULT_DIV
  - cnt = DEFAULT_DIV-1
  - tick = 0, sq = 0, pend = 0
- Reset overrides all other inputs, including an in-flight cfg_wr.
- Effective divisor: div_eff = (div == 0) ? 1 : div. A divisor of 0 behaves exactly like 1.
- Counter: down-counter cnt per channel. All outputs are registered.
- Disabled channel (ch_en=0):
  - cnt <= div_eff(shadow)-1, div_reg <= shadow, pend cleared.
  - tick = 0 and sq = 0 from the next edge.
- Enable latency: if ch_en is first sampled high at edge k, tick is high for the single cycle following edge k+div_eff, then every div_eff cycles thereafter.
- Boundary: an edge where ch_en=1 and cnt==0.
  - At a boundary: tick <= 1; cnt <= div_eff(next)-1.
  - At every other edge: tick <= 0 and cnt decrements.
- sq: high for the first floor(div_eff/2) cycles of each period, starting with the tick cycle; low for the rest.
  - div_eff=1: sq always 0.
  - div_eff=2: sq equals tick.
  - div_eff=5: 2 cycles high, 3 low.
- Config write (cfg_wr=1 at edge w):
  - shadow[cfg_ch] <= cfg_div and pend[cfg_ch] <= 1, both effective after w.
  - The write always succeeds; there is no back-pressure.
- Applying the shadow: at the first boundary strictly after w, div_reg <= shadow and pend clears. "next" = shadow if pend, else div_reg.
- Simultaneous write and boundary on the same channel: the boundary uses the old value; the new value applies at the following boundary.
- Back-to-back writes before a boundary: the last write wins.
- cfg_ch >= NCH: the write is ignored.
- Disable mid-period: counter state is discarded. Re-enable restarts a full period; no partial period and no stray tick.
- Channels are fully independent; there is no shared phase unless the optional feature below is compiled in.

Optional Feature:
- Macro: OSC_TICK_SYNC_EN.
- Defined: adds input port `sync` (1 bit).
  - An edge with sync=1 forces every enabled channel to behave as if at a boundary: pending divisors apply, cnt reloads, tick <= 1.
  - All channels become phase-aligned.
  - sync has priority over an ordinary boundary. Disabled channels ignore it.
- Undefined: the port is absent and channels free-run independently.

Decomposition:
- Package osc_tick_pkg: DIV_W default, DEFAULT_DIV default, function div_eff(), channel-index width helper.
- Sub-module osc_tick_chan: one channel holding counter, shadow, pend, tick, sq.
  - Instantiated NCH times via generate.
  - Top level decodes cfg_ch into per-channel write strobes and routes `sync`.

Test Plan:
- Reset with DEFAULT_DIV=128, ch_en=1 on ch0 from edge 0 -> first tick after edge 128; period 128; sq high 64 cycles, low 64; pend=0.
- Write cfg_ch=1, cfg_div=5 while ch1 runs at 128 -> pend[1]=1 until next ch1 boundary; tick spacing is 128 once, then 5; sq pattern 11000; pend clears at that boundary.
- cfg_div=0 and cfg_div=1 on ch2 -> tick high every cycle; sq constant 0.
- Write coinciding with ch3 boundary, then a second write of 3 before the next boundary -> old divisor used at the coincident boundary; next period is 3; the intermediate value is never applied.
- Drop ch_en[0] mid-period at cnt=40, re-raise 10 cycles later with div 8 -> no tick while disabled; first tick exactly 8 cycles after re-enable.
- With OSC_TICK_SYNC_EN: ch0 div 7 and ch1 div 11 free-running, pulse sync -> both tick the cycle after the sync edge; subsequent ticks at 7 and 11 from that point. cfg_ch=NCH write -> no state change.
